matrix_requant_wb_8x8: RTL and testbench
========================================

# matrix_requant_wb_8x8

Result write-back stage directly downstream of the 8x8 matrix FMA engine. On a start pulse (normally tied to the engine's done pulse) it captures the 64-element, 24-bit accumulator matrix. It then requantizes each element to signed 8 bits with a rounded arithmetic right shift and saturation. Finally it writes the result row by row (one 64-bit word per row, 8 words) into the same 64-bit-wide memory the engine reads its B operand from, so results can be chained as the next operation's input.

## Interface
- ACC_WIDTH, 24, accumulator element width; fixed element count 64 (8x8)
- ADDR_WIDTH, 8, memory address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; samples mat_in, shift, base_addr
- mat_in  in  64*ACC_WIDTH  element (r,c) at bits [(r*8+c)*ACC_WIDTH +: ACC_WIDTH], signed
- shift  in  5  right-shift amount; values >23 treated as 23
- base_addr  in  ADDR_WIDTH  address of row 0
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after last row accepted
- sat_flag  out  1  sticky: some element saturated in current/last transaction
- wr_en  out  1  write request
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  64  packed row; byte c at bits [c*8 +: 8] = element (row,c)
- wr_ready  in  1  memory accepts write when wr_en && wr_ready

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: on start=1, register mat_in, shift (clamped), base_addr; clear row counter and sat_flag; go to WRITE.
- WRITE: wr_en=1, wr_addr=(base_addr+row) mod 2^ADDR_WIDTH, wr_data=requantized row. On wr_en&&wr_ready: if row==7 go to DONE, else row++.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start while busy is ignored entirely; captured data is not disturbed.
- Requantization per element x (signed ACC_WIDTH), in ACC_WIDTH+1-bit signed arithmetic:
  - if shift>0, y = (x + 2^(shift-1)) >>> shift; else y = x.
  - q = 127 if y>127; -128 if y<-128; else y[7:0] (two's complement).
  - any clamp sets sat_flag (sticky until next accepted start).
- Each row's elements are evaluated before or as the row is presented; sat_flag reflects only rows already accepted, and is final when done pulses.
- Address wraps modulo 2^ADDR_WIDTH, with no error.

## Timing
- Reset values: busy=0, done=0, sat_flag=0, wr_en=0, wr_addr=0, wr_data=0; state IDLE, row=0.
- start sampled at edge T; WRITE from T+1 with row 0 presented at T+1.
- With wr_ready held high: rows 0..7 accepted at edges T+1..T+8, done high in cycle T+9, busy high T+1..T+9, back to IDLE at T+10. A new start is accepted at earliest at edge T+10.
- Each cycle of wr_ready=0 during WRITE adds one cycle. wr_en, wr_addr and wr_data are held stable until accepted.
- wr_en is never high outside WRITE. Exactly 8 writes per transaction.
- Reset asserted mid-transaction: immediate return to reset values; remaining rows are not written; no done pulse.

## Test plan
- mat_in all 58, shift=0, base=0x10, wr_ready=1 -> writes 0x3A3A3A3A3A3A3A3A to 0x10..0x17 on consecutive cycles T+1..T+8. done at T+9, sat_flag=0.
- mat_in all 58, shift=3 -> every byte 0x07 ((58+4)>>3). Element -5 with shift=1 -> 0xFE (-2).
- Element (0,0)=1000, element (7,7)=-1000, others 0, shift=0 -> word at base has byte0=0x7F; word at base+7 has byte7=0x80; sat_flag=1 at done. Next start with all zero inputs -> sat_flag clears.
- Identity-like result (diagonal 5, rest 0), base=0xFC -> addresses FC,FD,FE,FF,00,01,02,03. Row r word has 0x05 in byte r only.
- wr_ready low for 3 cycles while row 2 is presented -> wr_addr and wr_data stable throughout, row 2 written once, done at T+12. A start pulse during busy is ignored (no extra writes).
- rst_n low while row 4 is presented -> wr_en drops asynchronously, busy=0, no done. After release, a new start completes normally with 8 writes.

Source files
------------

// File: rtl/matrix_requant_wb_8x8.sv
// Write-back stage for the 8x8 FMA engine: captures the accumulator matrix,
// requantizes each element to int8 and writes it out one 64-bit row per beat.
module matrix_requant_wb_8x8 #(
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [64*ACC_WIDTH-1:0] mat_in,
    input  logic [4:0]              shift,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [63:0]             wr_data,
    input  logic                    wr_ready
);

    localparam int XW = ACC_WIDTH + 1;
    localparam logic [4:0] MAX_SHIFT = 5'(ACC_WIDTH - 1);
    localparam logic signed [XW-1:0] Q_MAX = XW'(127);
    localparam logic signed [XW-1:0] Q_MIN = XW'(-128);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t                       state;
    logic [63:0][ACC_WIDTH-1:0]   mat_q;
    logic [4:0]                   shift_q;
    logic [2:0]                   row;
    logic [7:0][8:0]              rq;
    logic [63:0]                  row_data;
    logic                         row_sat;
    logic                         accept;

    // Returns {saturated, int8}; the extra bit keeps x + rounding from overflowing.
    function automatic logic [8:0] requant(
        input logic [ACC_WIDTH-1:0] x,
        input logic [4:0]           sh
    );
        logic signed [XW-1:0] xe;
        logic signed [XW-1:0] rnd;
        logic signed [XW-1:0] y;
        logic [8:0]           r;
        xe  = $signed({x[ACC_WIDTH-1], x});
        rnd = '0;
        if (sh != 5'd0) begin
            rnd[sh - 5'd1] = 1'b1;
        end
        y = (xe + rnd) >>> sh;
        if (y > Q_MAX) begin
            r = {1'b1, 8'h7f};
        end else if (y < Q_MIN) begin
            r = {1'b1, 8'h80};
        end else begin
            r = {1'b0, y[7:0]};
        end
        return r;
    endfunction

    always_comb begin
        rq       = '0;
        row_data = '0;
        row_sat  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rq[c] = requant(mat_q[{row, 3'(c)}], shift_q);
            row_data[c*8 +: 8] = rq[c][7:0];
            row_sat = row_sat | rq[c][8];
        end
    end

    assign wr_data = row_data;
    assign accept  = (state == WRITE) && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mat_q    <= '0;
            shift_q  <= '0;
            row      <= '0;
            sat_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mat_q    <= mat_in;
                        shift_q  <= (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
                        row      <= '0;
                        sat_flag <= 1'b0;
                        wr_addr  <= base_addr;
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        sat_flag <= sat_flag | row_sat;
                        if (row == 3'd7) begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row     <= row + 3'd1;
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_requant_wb_8x8.sv
// Directed table-driven bench for matrix_requant_wb_8x8.
// Corner sequences cover stalls, start-while-busy and mid-transaction reset.
module tb_matrix_requant_wb_8x8;

    localparam int AW = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [64*AW-1:0] mat_in = '0;
    logic [4:0]       shift = '0;
    logic [7:0]       base_addr = '0;
    logic             busy;
    logic             done;
    logic             sat_flag;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [63:0]      wr_data;
    logic             wr_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    matrix_requant_wb_8x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mat_in    (mat_in),
        .shift     (shift),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] fill;
        logic [AW-1:0] diag;
        logic [AW-1:0] e00;
        logic [AW-1:0] e77;
        logic [4:0]    sh;
        logic [7:0]    base;
        logic [7:0]    qf;
        logic [7:0]    qd;
        logic [7:0]    q00;
        logic [7:0]    q77;
        logic          sat;
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(input int f, input int d, input int a,
                                input int b, input int sh, input int base,
                                input int qf, input int qd, input int qa,
                                input int qb, input int sat);
        vec_t v;
        v.fill = AW'(f);
        v.diag = AW'(d);
        v.e00  = AW'(a);
        v.e77  = AW'(b);
        v.sh   = 5'(sh);
        v.base = 8'(base);
        v.qf   = 8'(qf);
        v.qd   = 8'(qd);
        v.q00  = 8'(qa);
        v.q77  = 8'(qb);
        v.sat  = 1'(sat);
        return v;
    endfunction

    function automatic logic [AW-1:0] elem(input vec_t v, input int r, input int c);
        if (r == 0 && c == 0) return v.e00;
        if (r == 7 && c == 7) return v.e77;
        if (r == c) return v.diag;
        return v.fill;
    endfunction

    function automatic logic [63:0] exp_row(input vec_t v, input int r);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < 8; c++) begin
            if (r == 0 && c == 0) w[c*8 +: 8] = v.q00;
            else if (r == 7 && c == 7) w[c*8 +: 8] = v.q77;
            else if (r == c) w[c*8 +: 8] = v.qd;
            else w[c*8 +: 8] = v.qf;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                mat_in[(r*8+c)*AW +: AW] = elem(v, r, c);
            end
        end
        shift = v.sh;
        base_addr = v.base;
    endtask

    task automatic run(input vec_t v, input int stall_row, input int stall_n,
                       input bit poke, input string tag);
        int cyc;
        int nwr;
        int left;
        bit seen;
        @(negedge clk);
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        nwr = 0;
        left = stall_n;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            chk({tag, " busy"}, 64'(busy), 64'd1);
            if (wr_en) begin
                if (nwr < 8) begin
                    chk({tag, " addr"}, 64'(wr_addr), 64'(8'(v.base + 8'(nwr))));
                    chk({tag, " data"}, wr_data, exp_row(v, nwr));
                end else begin
                    chk({tag, " extra write"}, 64'(nwr), 64'd7);
                end
                if (nwr == stall_row && left > 0) begin
                    wr_ready = 1'b0;
                    left--;
                end else begin
                    wr_ready = 1'b1;
                    nwr++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                chk({tag, " done cycle"}, 64'(cyc), 64'(9 + stall_n));
                chk({tag, " sat_flag"}, 64'(sat_flag), 64'(v.sat));
                chk({tag, " wr_en at done"}, 64'(wr_en), 64'd0);
            end
            if (poke && cyc == 3) begin
                start = 1'b1;
                mat_in = '1;
                base_addr = 8'h00;
                shift = 5'd0;
            end else begin
                start = 1'b0;
            end
            if (!seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk({tag, " done timeout"}, 64'd0, 64'd1);
        chk({tag, " write count"}, 64'(nwr), 64'd8);
        @(negedge clk);
        chk({tag, " idle after"}, 64'({busy, done, wr_en}), 64'd0);
        wr_ready = 1'b1;
    endtask

    initial begin
        vt[0] = mk(58, 58, 58, 58, 0, 'h10, 'h3A, 'h3A, 'h3A, 'h3A, 0);
        vt[1] = mk(58, 58, 58, 58, 3, 'h20, 'h07, 'h07, 'h07, 'h07, 0);
        vt[2] = mk(-5, -5, -5, -5, 1, 'h30, 'hFE, 'hFE, 'hFE, 'hFE, 0);
        vt[3] = mk(0, 0, 1000, -1000, 0, 'h50, 'h00, 'h00, 'h7F, 'h80, 1);
        vt[4] = mk(0, 0, 0, 0, 0, 'h60, 'h00, 'h00, 'h00, 'h00, 0);
        vt[5] = mk(0, 5, 5, 5, 0, 'hFC, 'h00, 'h05, 'h05, 'h05, 0);
        vt[6] = mk(8388607, -8388608, 4194304, 4194303, 31, 'h70,
                   'h01, 'hFF, 'h01, 'h00, 0);
        vt[7] = mk(-129, 127, -128, 128, 0, 'h80, 'h80, 'h7F, 'h80, 'h7F, 1);
        vt[8] = mk(2039, 2040, -2056, -2057, 4, 'h90, 'h7F, 'h7F, 'h80, 'h80, 1);

        #1;
        chk("reset ctrl", 64'({busy, done, sat_flag, wr_en}), 64'd0);
        chk("reset addr", 64'(wr_addr), 64'd0);
        chk("reset data", wr_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run(vt[i], -1, 0, 1'b0, $sformatf("vec%0d", i));
        end

        run(vt[1], 2, 3, 1'b1, "stall");

        @(negedge clk);
        load(vt[5]);
        base_addr = 8'h40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst row4 addr", 64'(wr_addr), 64'h44);
        chk("rst row4 data", wr_data, 64'h0000_0005_0000_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst ctrl", 64'({busy, done, sat_flag, wr_en}), 64'd0);
        chk("rst addr", 64'(wr_addr), 64'd0);
        chk("rst data", wr_data, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst no done", 64'({done, wr_en, busy}), 64'd0);
        end
        rst_n = 1'b1;
        run(vt[3], -1, 0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
